// File: rtl/regfile_writeback_queue_if.sv
// Producer-to-regfile bundle for the writeback queue: two result handshakes,
// the register file write port, and hazard/occupancy status.
interface regfile_writeback_queue_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 32
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            alu_ready;
   logic            mem_valid;
   logic [4:0]      mem_rd;
   logic [XLEN-1:0] mem_data;
   logic            mem_ready;
   logic            hold;
   logic [4:0]      write_addr;
   logic [XLEN-1:0] write_data;
   logic            RegWrite;
   logic [31:0]     busy_mask;
   logic [CW-1:0]   count;

   modport master (
      output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, hold,
      input  alu_ready, mem_ready, write_addr, write_data, RegWrite, busy_mask, count
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, hold,
      output alu_ready, mem_ready, write_addr, write_data, RegWrite, busy_mask, count
   );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order writeback FIFO merging ALU and load results into the single
// register file write port, with a pending-write mask for decode stalls.
module regfile_writeback_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 32
) (
   input logic                      clk,
   input logic                      rst_n,
   regfile_writeback_queue_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [4:0]      ent_rd_q   [DEPTH];
   logic [4:0]      ent_rd_d   [DEPTH];
   logic [XLEN-1:0] ent_data_q [DEPTH];
   logic [XLEN-1:0] ent_data_d [DEPTH];
   logic            reg_write_q, reg_write_d;
   logic [4:0]      write_addr_q, write_addr_d;
   logic [XLEN-1:0] write_data_q, write_data_d;

   logic            full;
   logic            in_take;
   logic [4:0]      in_rd;
   logic [XLEN-1:0] in_data;
   logic            push;
   logic            pop;
   logic [31:0]     busy;

   assign full          = (count_q == CW'(DEPTH));
   assign bus.mem_ready = !full;
   assign bus.alu_ready = !full && !bus.mem_valid;

   // Load results win; x0 targets are consumed but never enqueued.
   always_comb begin
      in_take = 1'b0;
      in_rd   = 5'd0;
      in_data = '0;
      if (bus.mem_valid && !full) begin
         in_take = 1'b1;
         in_rd   = bus.mem_rd;
         in_data = bus.mem_data;
      end else if (bus.alu_valid && !full) begin
         in_take = 1'b1;
         in_rd   = bus.alu_rd;
         in_data = bus.alu_data;
      end
   end

   assign push = in_take && (in_rd != 5'd0);
   assign pop  = (count_q != '0) && !bus.hold;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      ent_rd_d     = ent_rd_q;
      ent_data_d   = ent_data_q;
      reg_write_d  = 1'b0;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      if (push) begin
         ent_rd_d[wr_ptr_q]   = in_rd;
         ent_data_d[wr_ptr_q] = in_data;
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         reg_write_d  = 1'b1;
         write_addr_d = ent_rd_q[rd_ptr_q];
         write_data_d = ent_data_q[rd_ptr_q];
         rd_ptr_d     = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         reg_write_q  <= 1'b0;
         write_addr_q <= '0;
         write_data_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         reg_write_q  <= reg_write_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
      end
   end

   // Entry storage needs no reset: validity comes from the pointers and count.
   always_ff @(posedge clk) begin
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
   end

   // An entry is live when its distance from the read pointer is below count.
   always_comb begin
      logic [PW-1:0] off;
      busy = '0;
      off  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         off = PW'(i) - rd_ptr_q;
         if ({1'b0, off} < count_q) busy[ent_rd_q[i]] = 1'b1;
      end
      if (reg_write_q) busy[write_addr_q] = 1'b1;
      busy[0] = 1'b0;
   end

   assign bus.busy_mask  = busy;
   assign bus.RegWrite   = reg_write_q;
   assign bus.write_addr = write_addr_q;
   assign bus.write_data = write_data_q;
   assign bus.count      = count_q;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: expected writes go into a
// scoreboard queue and a negedge monitor checks every RegWrite against it.
module tb_regfile_writeback_queue;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned XLEN  = 32;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_t;

   logic clk;
   logic rst_n;
   int   total;
   int   passed;
   wb_t  sb_q[$];

   regfile_writeback_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

   regfile_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   // Monitor: every issued write must match the oldest expected write.
   always @(negedge clk) begin
      if (bus.RegWrite === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_write: got addr %0d data %0h required no write",
                     bus.write_addr, bus.write_data);
         end else begin
            wb_t e;
            e = sb_q.pop_front();
            chk("wb_addr", 64'(bus.write_addr), 64'(e.addr));
            chk("wb_data", 64'(bus.write_data), 64'(e.data));
         end
      end
   end

   // Offer one ALU result, wait (bounded) until accepted; returns at posedge+1.
   task automatic alu_xfer(input logic [4:0] rd, input logic [31:0] d);
      int n;
      bus.alu_valid = 1'b1;
      bus.alu_rd    = rd;
      bus.alu_data  = d;
      n = 0;
      @(negedge clk);
      while (bus.alu_ready !== 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) begin
         total++;
         $display("FAIL alu_accept_timeout: got ready %b required 1 for rd %0d", bus.alu_ready, rd);
      end
      @(posedge clk);
      #1 bus.alu_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
      wb_t e;
      e.addr = a;
      e.data = d;
      sb_q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required $finish");
      $fatal(1);
   end

   initial begin
      total = 0;
      passed = 0;
      rst_n = 1'b0;
      bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
      bus.hold = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_regwrite", 64'(bus.RegWrite), 64'd0);
      chk("rst_busy", 64'(bus.busy_mask), 64'd0);
      chk("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
      chk("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
      @(posedge clk); #1;

      // single write
      push_exp(5'd5, 32'hDEADBEEF);
      alu_xfer(5'd5, 32'hDEADBEEF);
      @(negedge clk);
      chk("single_count1", 64'(bus.count), 64'd1);
      chk("single_busy_a", 64'(bus.busy_mask), 64'h20);
      chk("single_nowrite_yet", 64'(bus.RegWrite), 64'd0);
      @(negedge clk);
      chk("single_write", 64'(bus.RegWrite), 64'd1);
      chk("single_busy_b", 64'(bus.busy_mask), 64'h20);
      chk("single_count0", 64'(bus.count), 64'd0);
      @(negedge clk);
      chk("single_write_done", 64'(bus.RegWrite), 64'd0);
      chk("single_busy_clr", 64'(bus.busy_mask), 64'd0);
      @(posedge clk); #1;

      // arbitration: load wins
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h11;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h22;
      push_exp(5'd3, 32'h11);
      push_exp(5'd4, 32'h22);
      @(negedge clk);
      chk("arb_alu_ready", 64'(bus.alu_ready), 64'd0);
      chk("arb_mem_ready", 64'(bus.mem_ready), 64'd1);
      @(posedge clk);
      #1 bus.mem_valid = 1'b0;
      alu_xfer(5'd4, 32'h22);
      idle(4);

      // full and pointer wrap
      bus.hold = 1'b1;
      for (int i = 1; i <= 6; i++) push_exp(5'(i), 32'(i) * 32'h100);
      for (int i = 1; i <= 4; i++) alu_xfer(5'(i), 32'(i) * 32'h100);
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h500;
      @(negedge clk);
      chk("full_count", 64'(bus.count), 64'd4);
      chk("full_alu_ready", 64'(bus.alu_ready), 64'd0);
      chk("full_mem_ready", 64'(bus.mem_ready), 64'd0);
      chk("full_busy", 64'(bus.busy_mask), 64'h1E);
      @(posedge clk);
      #1 bus.hold = 1'b0;
      alu_xfer(5'd5, 32'h500);
      alu_xfer(5'd6, 32'h600);
      idle(8);
      chk("wrap_drained", 64'(bus.count), 64'd0);

      // x0 drop
      alu_xfer(5'd0, 32'hFFFFFFFF);
      @(negedge clk);
      chk("x0_count", 64'(bus.count), 64'd0);
      chk("x0_regwrite", 64'(bus.RegWrite), 64'd0);
      chk("x0_busy", 64'(bus.busy_mask), 64'd0);
      @(negedge clk);
      chk("x0_regwrite_later", 64'(bus.RegWrite), 64'd0);
      @(posedge clk); #1;

      // reset mid-operation: only rd=8 leaves before reset
      bus.hold = 1'b1;
      push_exp(5'd8, 32'h8);
      alu_xfer(5'd8, 32'h8);
      alu_xfer(5'd9, 32'h9);
      alu_xfer(5'd10, 32'hA);
      alu_xfer(5'd11, 32'hB);
      bus.hold = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("pre_rst_count", 64'(bus.count), 64'd3);
      chk("pre_rst_regwrite", 64'(bus.RegWrite), 64'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_regwrite", 64'(bus.RegWrite), 64'd0);
      chk("mid_rst_count", 64'(bus.count), 64'd0);
      chk("mid_rst_busy", 64'(bus.busy_mask), 64'd0);
      chk("mid_rst_mem_ready", 64'(bus.mem_ready), 64'd1);
      @(posedge clk); #1;
      idle(5);

      // same-rd ordering
      push_exp(5'd7, 32'hA);
      push_exp(5'd7, 32'hB);
      alu_xfer(5'd7, 32'hA);
      alu_xfer(5'd7, 32'hB);
      @(negedge clk);
      chk("same_busy_a", 64'(bus.busy_mask), 64'h80);
      @(negedge clk);
      chk("same_busy_b", 64'(bus.busy_mask), 64'h80);
      chk("same_last_data", 64'(bus.write_data), 64'hB);
      @(negedge clk);
      chk("same_busy_clr", 64'(bus.busy_mask), 64'd0);
      @(posedge clk); #1;
      idle(3);

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Write-side front end for the core's 32x32 register file. It accepts results from two producers, the ALU and the load unit, through valid/ready handshakes. It buffers them in an in-order FIFO and drives the register file's `write_addr` / `write_data` / `RegWrite` port one write per cycle. It also exports a pending-write mask so decode can stall on read-after-write hazards.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `XLEN`, default 32: data width.

Ports:
- `clk`  in  1  core clock; all state updates on posedge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `alu_valid`  in  1  ALU result valid.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `alu_ready`  out  1  ALU result accepted this cycle when high together with `alu_valid`.
- `mem_valid`  in  1  load result valid.
- `mem_rd`  in  5  load destination register.
- `mem_data`  in  XLEN  load result.
- `mem_ready`  out  1  load result accepted this cycle when high together with `mem_valid`.
- `hold`  in  1  suppresses dequeue this cycle (debug access / pipeline freeze).
- `write_addr`  out  5  register file write address.
- `write_data`  out  XLEN  register file write data.
- `RegWrite`  out  1  register file write enable.
- `busy_mask`  out  32  bit i set while a write to x i is queued or in the output stage.
- `count`  out  clog2(DEPTH)+1  number of occupied FIFO entries.

## Operation
- **Storage.** Circular FIFO with `DEPTH` entries of {rd, data}. Read/write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. `count` is a separate register.
- **Ready.**
  - `full` = (`count` == DEPTH).
  - `mem_ready` = !`full`.
  - `alu_ready` = !`full` && !`mem_valid`. Load results always win arbitration.
  - Neither ready depends on a dequeue in the same cycle.
  - Both ready outputs are combinational from registered state and `mem_valid` only; there is no path from `alu_valid` to any ready.
- **Enqueue.**
  - At most one enqueue per cycle: the load result if `mem_valid` && `mem_ready`, else the ALU result if `alu_valid` && `alu_ready`.
  - An accepted transfer with rd == 0 is consumed (ready stays high), but nothing is enqueued, `count` is unchanged and no write is ever issued.
- **Dequeue.**
  - Occurs when `count` > 0 && !`hold`.
  - The head entry loads the output registers: `write_addr` <= rd, `write_data` <= data, `RegWrite` <= 1.
  - Otherwise `RegWrite` <= 0 while `write_addr` / `write_data` hold their last values.
- **Simultaneous enqueue and dequeue.**
  - `count` is unchanged; both pointers advance.
  - With `count` == 0, an entry enqueued this cycle is not dequeued this cycle; there is no bypass.
  - With `count` == DEPTH, a dequeue this cycle does not permit an enqueue.
- **Ordering.** Writes leave in acceptance order. Two queued writes to the same rd both issue, and the later one wins in the register file.
- **busy_mask.** Combinational OR of the one-hot decode of rd for every valid FIFO entry, plus `write_addr` when `RegWrite` is 1. Bit 0 is always 0.
- **Reset** (`rst_n` low at a posedge):
  - pointers, `count`, `RegWrite`, `write_addr`, `write_data` <= 0;
  - `busy_mask` = 0 as a consequence;
  - queued entries are discarded; an in-flight `RegWrite` is cleared and no write occurs at the next edge.
  - After reset, `mem_ready` = 1 and `alu_ready` = !`mem_valid`.

## Timing
- Enqueue at edge N (FIFO was empty, `hold` low):
  - `count` = 1 during cycle N to N+1;
  - dequeue at edge N+1, so `RegWrite` = 1 during N+1 to N+2;
  - register file commits at edge N+2;
  - the `busy_mask` bit is set from after edge N until edge N+2.
- Sustained throughput: one write per cycle when `hold` stays low.
- `hold` high for k cycles adds k cycles of latency. The FIFO fills after DEPTH accepted transfers, and ready drops the cycle `count` reaches DEPTH.
- Back-to-back accepts and dequeues across the pointer wrap (pointer DEPTH-1 to 0) must not lose or reorder entries.

## Test plan
- **Single write.** After reset, `alu_valid`=1, rd=5, data=0xDEADBEEF for one cycle → `RegWrite`=1 exactly one cycle, two edges later, with `write_addr`=5 and `write_data`=0xDEADBEEF; `busy_mask`[5]=1 for two cycles, then 0.
- **Arbitration.** `mem_valid` and `alu_valid` both high (mem rd=3 data=0x11, alu rd=4 data=0x22) → `alu_ready`=0 and the mem write issues first; the next cycle, with `mem_valid` low, the alu write issues; writes appear to 3 then 4.
- **Full and wrap.** `hold`=1, offer 6 ALU results rd=1..6 → the first 4 are accepted, `count`=4, `alu_ready`=0; release `hold` → writes 1,2,3,4 on consecutive cycles; rd=5 is accepted the cycle after the first dequeue; writes 5,6 follow in order.
- **x0 drop.** ALU rd=0 data=0xFFFFFFFF → accepted, `count` stays 0, `RegWrite` stays 0, `busy_mask`=0.
- **Reset mid-operation.** 3 entries queued with `RegWrite` high, `rst_n` low for one edge → `RegWrite`=0, `count`=0, `busy_mask`=0; no further writes issue.
- **Same-rd ordering.** rd=7 data=0xA, then rd=7 data=0xB → both writes issue, 0xB last; `busy_mask`[7] stays set until the second write leaves the output stage.
